// File: rtl/intersection_phase_arbiter.sv
// intersection_phase_arbiter
// Round-robin green-phase scheduler for one intersection. It enforces minimum and
// maximum green times, sequences yellow and all-red clearance, and drives the
// 3-bit lamp code of every approach (001 green, 010 yellow, 100 red).
// A built-in prescaler produces the timing tick; every state change happens on a tick.
// Optional pedestrian walk phase: define PED_PHASE_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_GREEN  | owner lamp green, all other approaches red
// ST_YELLOW | owner lamp yellow, all other approaches red
// ST_ALLRED | all lamps red; next owner (or walk) chosen on exit
// ST_WALK   | all lamps red, walk lamp lit (PED_PHASE_EN builds only)

module intersection_phase_arbiter #(
    parameter int N_APPR    = 4,
    parameter int TICK_DIV  = 4,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 15,
    parameter int YEL_T     = 3,
    parameter int ALLRED_T  = 1,
`ifdef PED_PHASE_EN
    parameter int WALK_T    = 4,
`endif
    parameter int CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_APPR-1:0]         req,
`ifdef PED_PHASE_EN
    input  logic                      ped_req,
    output logic                      walk,
`endif
    output logic [3*N_APPR-1:0]       light,
    output logic [$clog2(N_APPR)-1:0] owner,
    output logic                      phase_start,
    output logic                      tick
);

    localparam int OW = $clog2(N_APPR);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [PW-1:0]    CNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W:0]   E_GMIN   = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0]   E_GMAX   = (CNT_W+1)'(GREEN_MAX);
    localparam logic [CNT_W:0]   E_YEL    = (CNT_W+1)'(YEL_T);
    localparam logic [CNT_W:0]   E_AR     = (CNT_W+1)'(ALLRED_T);
`ifdef PED_PHASE_EN
    localparam logic [CNT_W:0]   E_WALK   = (CNT_W+1)'(WALK_T);
`endif
    localparam logic [CNT_W-1:0] GMAX_T   = CNT_W'(GREEN_MAX);

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
`ifdef PED_PHASE_EN
        , ST_WALK = 2'd3
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic [CNT_W-1:0]     timer_q, timer_d;
    logic [OW-1:0]        owner_q, owner_d;
    logic [N_APPR-1:0]    pending_q, pending_d;
    logic [3*N_APPR-1:0]  light_q, light_d;
    logic                 phase_start_q, phase_start_d;
`ifdef PED_PHASE_EN
    logic                 ped_pending_q, ped_pending_d;
    logic                 after_walk_q, after_walk_d;
    logic                 walk_q, walk_d;
    logic                 ped_clr;
`endif

    logic [CNT_W:0]       e;
    logic [N_APPR-1:0]    own_oh;
    logic [N_APPR-1:0]    grant_oh;
    logic [OW-1:0]        nxt_owner;
    logic                 others;
    logic                 go_walk;

    // Next-state, timer, pending and registered-output computation.
    always_comb begin
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + PW'(1);
        tick_d = (cnt_d == CNT_LAST);

        e      = {1'b0, timer_q} + (CNT_W+1)'(1);
        own_oh = {{(N_APPR-1){1'b0}}, 1'b1} << owner_q;
        others = |(pending_q & ~own_oh);

        // Reverse scan so the nearest pending index after the owner wins;
        // with nothing pending the current owner is re-granted.
        nxt_owner = owner_q;
        for (int k = N_APPR - 1; k >= 1; k--) begin
            if (pending_q[(int'(owner_q) + k) % N_APPR]) begin
                nxt_owner = OW'((int'(owner_q) + k) % N_APPR);
            end
        end

        go_walk = 1'b0;
`ifdef PED_PHASE_EN
        go_walk       = ped_pending_q && !after_walk_q;
        ped_clr       = 1'b0;
        after_walk_d  = after_walk_q;
`endif

        state_d       = state_q;
        timer_d       = timer_q;
        owner_d       = owner_q;
        grant_oh      = '0;
        phase_start_d = 1'b0;

        case (state_q)
            ST_GREEN: begin
                if (tick_q) begin
                    if (others && ((e >= E_GMIN && !req[owner_q]) || e >= E_GMAX)) begin
                        state_d = ST_YELLOW;
                        timer_d = '0;
                    end else if (e >= E_GMAX) begin
                        timer_d = GMAX_T;
                    end else begin
                        timer_d = e[CNT_W-1:0];
                    end
                end
            end
            ST_YELLOW: begin
                if (tick_q) begin
                    if (e == E_YEL) begin
                        state_d = ST_ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = e[CNT_W-1:0];
                    end
                end
            end
            ST_ALLRED: begin
                if (tick_q) begin
                    if (e == E_AR) begin
                        timer_d = '0;
                        if (go_walk) begin
`ifdef PED_PHASE_EN
                            state_d = ST_WALK;
                            ped_clr = 1'b1;
`endif
                        end else begin
                            state_d       = ST_GREEN;
                            owner_d       = nxt_owner;
                            grant_oh      = {{(N_APPR-1){1'b0}}, 1'b1} << nxt_owner;
                            phase_start_d = 1'b1;
`ifdef PED_PHASE_EN
                            after_walk_d  = 1'b0;
`endif
                        end
                    end else begin
                        timer_d = e[CNT_W-1:0];
                    end
                end
            end
`ifdef PED_PHASE_EN
            ST_WALK: begin
                if (tick_q) begin
                    if (e == E_WALK) begin
                        state_d      = ST_ALLRED;
                        timer_d      = '0;
                        after_walk_d = 1'b1;
                    end else begin
                        timer_d = e[CNT_W-1:0];
                    end
                end
            end
`endif
            default: begin
                // Corrupted state register: fall back to full clearance.
                state_d = ST_ALLRED;
                timer_d = '0;
            end
        endcase

        // Set wins over clear except for the approach being granted this edge.
        pending_d = (pending_q | req) & ~grant_oh;
`ifdef PED_PHASE_EN
        ped_pending_d = (ped_pending_q | ped_req) & ~ped_clr;
        walk_d        = (state_d == ST_WALK);
`endif

        for (int i = 0; i < N_APPR; i++) begin
            light_d[3*i +: 3] = LAMP_R;
            if (i == int'(owner_d)) begin
                if (state_d == ST_GREEN) begin
                    light_d[3*i +: 3] = LAMP_G;
                end else if (state_d == ST_YELLOW) begin
                    light_d[3*i +: 3] = LAMP_Y;
                end
            end
        end
    end

    // State register, prescaler, timers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_GREEN;
            cnt_q         <= '0;
            tick_q        <= 1'b0;
            timer_q       <= '0;
            owner_q       <= '0;
            pending_q     <= '0;
            light_q       <= {{(N_APPR-1){LAMP_R}}, LAMP_G};
            phase_start_q <= 1'b0;
`ifdef PED_PHASE_EN
            ped_pending_q <= 1'b0;
            after_walk_q  <= 1'b0;
            walk_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            timer_q       <= timer_d;
            owner_q       <= owner_d;
            pending_q     <= pending_d;
            light_q       <= light_d;
            phase_start_q <= phase_start_d;
`ifdef PED_PHASE_EN
            ped_pending_q <= ped_pending_d;
            after_walk_q  <= after_walk_d;
            walk_q        <= walk_d;
`endif
        end
    end

    assign light       = light_q;
    assign owner       = owner_q;
    assign phase_start = phase_start_q;
    assign tick        = tick_q;
`ifdef PED_PHASE_EN
    assign walk        = walk_q;
`endif

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Scoreboard bench for intersection_phase_arbiter: a tick-level reference model
// pushes expected outputs each clock, a negedge monitor pops and compares.
module tb_intersection_phase_arbiter;

    localparam int N     = 4;
    localparam int TD    = 4;
    localparam int GMIN  = 5;
    localparam int GMAX  = 15;
    localparam int YEL   = 3;
    localparam int AR    = 1;
    localparam int WT    = 4;
    localparam int OUT_W = 3*N + 2 + 3;
    localparam logic [3*N-1:0] RST_LIGHT = {{(N-1){3'b100}}, 3'b001};

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic           ped_in;
    logic           walk_w;
    wire  [3*N-1:0] light;
    wire  [1:0]     owner;
    wire            phase_start;
    wire            tick;

`ifdef PED_PHASE_EN
    logic ped_req;
    wire  walk;
    assign walk_w = walk;
    assign ped_in = ped_req;
`else
    assign walk_w = 1'b0;
    assign ped_in = 1'b0;
`endif

    always #5 clk = ~clk;

    intersection_phase_arbiter #(
        .N_APPR(N), .TICK_DIV(TD), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
        .YEL_T(YEL), .ALLRED_T(AR),
`ifdef PED_PHASE_EN
        .WALK_T(WT),
`endif
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
`ifdef PED_PHASE_EN
        .ped_req(ped_req),
        .walk(walk),
`endif
        .light(light),
        .owner(owner),
        .phase_start(phase_start),
        .tick(tick)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int n_print = 0;

    // Reference model: phase 0 green, 1 yellow, 2 all-red, 3 walk.
    int m_phase, m_ticks, m_owner, m_cyc;
    bit m_pend [N];
    bit m_ped, m_after;
    logic [OUT_W-1:0] sb_q [$];

    function automatic logic [OUT_W-1:0] model_out(input bit ps, input bit tk);
        logic [3*N-1:0] l;
        for (int i = 0; i < N; i++) begin
            if (i == m_owner && m_phase == 0)      l[3*i +: 3] = 3'b001;
            else if (i == m_owner && m_phase == 1) l[3*i +: 3] = 3'b010;
            else                                   l[3*i +: 3] = 3'b100;
        end
        return {l, 2'(m_owner), ps, tk, (m_phase == 3)};
    endfunction

    function automatic logic [OUT_W-1:0] reset_out();
        return {RST_LIGHT, 2'b00, 3'b000};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ticks = 0; m_owner = 0; m_cyc = 0;
        m_ped = 0; m_after = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 0;
    endtask

    // Model step on every clock edge; expected outputs go to the scoreboard.
    always @(posedge clk) begin
        bit tk, ps, others, go_walk, pedclr;
        int el, grant;
        if (!rst_n) begin
            model_reset();
            sb_q.push_back(model_out(1'b0, 1'b0));
        end else begin
            tk = (m_cyc % TD == TD - 1);
            m_cyc++;
            ps = 0; grant = -1; pedclr = 0;
            if (tk) begin
                el = m_ticks + 1;
                case (m_phase)
                    0: begin
                        others = 0;
                        for (int j = 0; j < N; j++) if (j != m_owner && m_pend[j]) others = 1;
                        if (others && ((el >= GMIN && !req[m_owner]) || el >= GMAX)) begin
                            m_phase = 1; m_ticks = 0;
                        end else begin
                            m_ticks = (el > GMAX) ? GMAX : el;
                        end
                    end
                    1: if (el == YEL) begin m_phase = 2; m_ticks = 0; end else m_ticks = el;
                    2: if (el == AR) begin
                        m_ticks = 0;
                        go_walk = m_ped && !m_after;
                        if (go_walk) begin
                            m_phase = 3; pedclr = 1;
                        end else begin
                            grant = m_owner;
                            for (int k = 1; k < N; k++) begin
                                if (grant == m_owner && m_pend[(m_owner + k) % N])
                                    grant = (m_owner + k) % N;
                            end
                            m_owner = grant; m_phase = 0; ps = 1; m_after = 0;
                        end
                    end else m_ticks = el;
                    default: if (el == WT) begin m_phase = 2; m_ticks = 0; m_after = 1; end
                             else m_ticks = el;
                endcase
            end
            for (int j = 0; j < N; j++) m_pend[j] = m_pend[j] | req[j];
            if (grant >= 0) m_pend[grant] = 0;
            m_ped = pedclr ? 1'b0 : (m_ped | ped_in);
            sb_q.push_back(model_out(ps, (m_cyc % TD == TD - 1)));
        end
    end

    // Monitor: pop and compare every cycle, plus the one-lamp safety check.
    always @(negedge clk) begin
        logic [OUT_W-1:0] got, want;
        int lit;
        got = {light, owner, phase_start, tick, walk_w};
        if (!rst_n) begin
            sb_q.delete();
            want = reset_out();
        end else if (sb_q.size() == 0) begin
            want = '0;
            n_miss++;
            $display("FAIL sb_empty t=%0t got=%h want=<none>", $time, got);
        end else begin
            want = sb_q.pop_front();
        end
        n_vec++;
        if (got !== want) begin
            n_miss++;
            if (n_print < 30) begin
                n_print++;
                $display("FAIL outputs t=%0t got=%h want=%h", $time, got, want);
            end
        end
        lit = 0;
        for (int i = 0; i < N; i++) if (light[3*i +: 3] != 3'b100) lit++;
        n_vec++;
        if (lit > 1) begin
            n_miss++;
            $display("FAIL safety t=%0t got=%0d lit lamps want<=1", $time, lit);
        end
    end

    task automatic check(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic wait_grant(input int who, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (phase_start && owner == 2'(who)) ok = 1;
        end
    endtask

    task automatic pulse(input logic [N-1:0] v);
        @(negedge clk); #1 req = v;
        @(negedge clk); #1 req = '0;
    endtask

    task automatic cycles_to_yellow(input int lamp, input int drop_at, output int cyc);
        bit seen;
        seen = 0; cyc = 0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            cyc++;
            if (light[3*lamp +: 3] == 3'b010) seen = 1;
            else if (cyc == drop_at) begin #1 req = '0; end
        end
    endtask

    initial begin
        bit ok;
        int cnt_ps, cnt_tk, cyc, wcyc, bad;
        req = '0; rst_n = 1'b0;
`ifdef PED_PHASE_EN
        ped_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        @(posedge clk); #3 rst_n = 1'b1;

        // Idle after reset: green 0 holds, no phase_start, tick every TD cycles.
        cnt_ps = 0; cnt_tk = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (phase_start) cnt_ps++;
            if (tick) cnt_tk++;
        end
        check("idle_phase_start", cnt_ps, 0);
        check("idle_ticks", cnt_tk, 200 / TD);
        check("idle_light", int'(light), int'(RST_LIGHT));

        // Single pulse on approach 2.
        pulse(4'b0100);
        wait_grant(2, 400, ok);
        check("grant_2", int'(ok), 1);

        // Wrap-around order from owner 2: 3 then 1.
        pulse(4'b1010);
        wait_grant(3, 400, ok);
        check("grant_3_first", int'(ok), 1);
        wait_grant(1, 400, ok);
        check("grant_1_second", int'(ok), 1);

        // req[0] held with other demand: green lasts GREEN_MAX ticks.
        pulse(4'b0001);
        wait_grant(0, 400, ok);
        check("grant_0_a", int'(ok), 1);
        #1 req = 4'b0011;
        @(negedge clk); #1 req = 4'b0001;
        cycles_to_yellow(0, -1, cyc);
        check("green_max_cycles", cyc + 1, GMAX * TD);
        req = '0;
        wait_grant(1, 400, ok);
        check("grant_1_after_max", int'(ok), 1);

        // req[0] dropped after 8 ticks: yellow on the following tick.
        pulse(4'b0001);
        wait_grant(0, 400, ok);
        check("grant_0_b", int'(ok), 1);
        #1 req = 4'b0011;
        @(negedge clk); #1 req = 4'b0001;
        cycles_to_yellow(0, 8 * TD - 1, cyc);
        check("green_drop_cycles", cyc + 1, 9 * TD);
        req = '0;
        wait_grant(1, 400, ok);
        check("grant_1_after_drop", int'(ok), 1);

        // Asynchronous reset in the middle of yellow on approach 1.
        pulse(4'b0100);
        ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (light[5:3] == 3'b010) ok = 1;
        end
        check("yellow_1_seen", int'(ok), 1);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("rst_light", int'(light), int'(RST_LIGHT));
        check("rst_owner", int'(owner), 0);
        check("rst_phase_start", int'(phase_start), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cnt_ps = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (phase_start) cnt_ps++;
        end
        check("rst_pending_cleared", cnt_ps, 0);

`ifdef PED_PHASE_EN
        // Pedestrian request during green 0 with req[1] pending.
        @(negedge clk); #1 req = 4'b0010; ped_req = 1'b1;
        @(negedge clk); #1 req = '0; ped_req = 1'b0;
        ok = 0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            if (walk) ok = 1;
        end
        check("walk_seen", int'(ok), 1);
        wcyc = 0; bad = 0;
        for (int c = 0; c < 100 && walk; c++) begin
            wcyc++;
            if (light != {N{3'b100}}) bad++;
            @(negedge clk);
        end
        check("walk_cycles", wcyc, WT * TD);
        check("walk_all_red", bad, 0);
        wait_grant(1, 400, ok);
        check("grant_1_after_walk", int'(ok), 1);
`else
        wcyc = 0; bad = 0;
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #1;
            for (int i = 0; i < N; i++) if ($urandom_range(15) == 0) req[i] = ~req[i];
`ifdef PED_PHASE_EN
            ped_req = ($urandom_range(63) == 0);
`endif
            if ($urandom_range(1499) == 0) begin
                @(posedge clk); #3 rst_n = 1'b0;
                @(posedge clk); #3 rst_n = 1'b1;
            end
        end
        req = '0;
        repeat (4) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
